id_ex_pipeline_register: RTL and testbench
==========================================

# id_ex_pipeline_register

Sequential ID/EX stage boundary that sits directly downstream of the load-use hazard detection unit. It captures decoded instruction fields from ID each cycle, inserts a bubble when the hazard unit asserts stall, kills the entering instruction on a branch flush, and freezes on a back-pressure hold. It returns `is_load_instruction_ex_o` and `rd_label_ex_o` to the hazard unit, delays the load-store forward select into EX, and keeps saturating bubble and flush counters for performance debug.

## Interface
- `XLEN`, 32: data/PC width.
- `CNT_W`, 16: width of the bubble and flush counters.

- `clk_i` in 1: the single clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `hold_i` in 1: downstream (MEM) back-pressure; freezes all state.
- `flush_i` in 1: branch/jump redirect resolved in EX; kills the instruction entering from ID.
- `stall_i` in 1: hazard-unit stall; insert a bubble.
- `load_store_forward_sel_i` in 1: hazard-unit load→store forward select.
- `valid_id_i` in 1: ID holds a real instruction.
- `pc_id_i`, `rs1_data_id_i`, `rs2_data_id_i`, `imm_id_i` in XLEN: decoded data fields.
- `rs1_label_id_i`, `rs2_label_id_i`, `rd_label_id_i` in 5: register indices.
- `alu_op_id_i` in 4: ALU operation.
- `alu_src_id_i`, `is_load_id_i`, `is_store_id_i`, `reg_write_id_i`, `mem_to_reg_id_i`, `branch_id_i` in 1 each: control bits.
- Each of the above ID fields has a matching `*_ex_o` output of the same width, for example `pc_ex_o` and `rd_label_ex_o`. The load bit is output as `is_load_instruction_ex_o`.
- `valid_ex_o` out 1: EX holds a real instruction.
- `load_store_forward_sel_ex_o` out 1: registered forward select for the EX/MEM store-data mux.
- `bubble_count_o`, `flush_count_o` out CNT_W: saturating event counters.

## Operation
- One register stage. On each rising edge, the first matching rule in this priority list applies:
  1. `rst_i`: every output is cleared to 0, including both counters.
  2. `hold_i`: every register keeps its value. This includes the counters. `flush_i` and `stall_i` are ignored, because a flush source stays asserted while EX is held.
  3. `flush_i`: load a kill. `flush_count_o` increments.
  4. `stall_i`: load a bubble. `bubble_count_o` increments.
  5. Otherwise: capture every ID field. `valid_ex_o` takes `valid_id_i`, and `load_store_forward_sel_ex_o` takes `load_store_forward_sel_i`.
- Kill and bubble produce the same register contents:
  - `valid_ex_o`, `reg_write_ex_o`, `is_load_instruction_ex_o`, `is_store_ex_o`, `mem_to_reg_ex_o`, `branch_ex_o`, `load_store_forward_sel_ex_o` = 0.
  - `rd_label_ex_o`, `rs1_label_ex_o`, `rs2_label_ex_o` = 0, so the EX stage can never match a hazard or forward.
  - `alu_op_ex_o` = 0 and `alu_src_ex_o` = 0.
  - Data fields (pc, rs1/rs2 data, imm) hold their previous values.
- When a captured instruction has `valid_id_i` = 0, every control bit is forced to 0 in the same way as a bubble, and the labels are still captured.
- Counters stop at all-ones and never wrap.
- Flush and stall asserted together: flush wins. Only `flush_count_o` increments.
- This block does not gate the IF/ID register or the PC. The upstream stage holds them using the same `stall_i`.

## Timing
- Capture latency is 1 cycle. ID values present before edge N appear on the outputs after edge N.
- All outputs are registered. There is no combinational path from input to output.
- A bubble is visible on the outputs for exactly one cycle per stalled edge. During that cycle the hazard unit sees `is_load_instruction_ex_o` = 0, so a single load-use stall self-clears after one cycle.
- Reset is synchronous: outputs go to 0 at the first edge where `rst_i` = 1 and stay there while it remains high. Reset asserted mid-hold or mid-stall overrides both.
- After `rst_i` falls, the first non-hold, non-stall, non-flush edge captures ID normally.

## Test plan
- Reset: drive every ID input nonzero with `rst_i` = 1 for 2 edges → all outputs 0, including the counters. Release reset and feed pc=0x100, rd=5 → `pc_ex_o`=0x100, `rd_label_ex_o`=5, `valid_ex_o`=1 one edge later.
- Load-use: `lw x5` followed by `add x6,x5,x1`, with `stall_i` high for one edge → EX shows the lw, then a bubble (valid=0, rd=0, reg_write=0) for one cycle, then the add. `bubble_count_o`=1.
- Load-store forward: `load_store_forward_sel_i`=1 with `sw x5` in ID → after the edge, `load_store_forward_sel_ex_o`=1 and `is_store_ex_o`=1. No bubble is inserted and the counter is unchanged.
- Flush with stall: `flush_i`=1 and `stall_i`=1 on the same edge → kill contents are loaded, `flush_count_o`=1 and `bubble_count_o`=0. Data fields keep their prior values.
- Hold: EX holds pc=0x200, then `hold_i`=1 for 3 edges while `flush_i`, `stall_i` and new ID values toggle → outputs and counters stay unchanged. The edge after `hold_i` falls applies the rule for the inputs present at that edge.
- Saturation: with CNT_W=4, assert `stall_i` for 20 edges → `bubble_count_o` stops at 15.

Source files
------------

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline boundary register.
// Captures decoded ID fields each cycle. A hazard stall turns the entering
// slot into a bubble, and a branch flush turns it into a kill. A downstream
// hold freezes everything, including the counters. A bubble and a kill clear
// every control bit and every register label. Data fields keep their previous
// values, so the datapath does not toggle on a dead slot.
module id_ex_pipeline_register #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             load_store_forward_sel_i,
    input  logic             valid_id_i,
    input  logic [XLEN-1:0]  pc_id_i,
    input  logic [XLEN-1:0]  rs1_data_id_i,
    input  logic [XLEN-1:0]  rs2_data_id_i,
    input  logic [XLEN-1:0]  imm_id_i,
    input  logic [4:0]       rs1_label_id_i,
    input  logic [4:0]       rs2_label_id_i,
    input  logic [4:0]       rd_label_id_i,
    input  logic [3:0]       alu_op_id_i,
    input  logic             alu_src_id_i,
    input  logic             is_load_id_i,
    input  logic             is_store_id_i,
    input  logic             reg_write_id_i,
    input  logic             mem_to_reg_id_i,
    input  logic             branch_id_i,
    output logic             valid_ex_o,
    output logic [XLEN-1:0]  pc_ex_o,
    output logic [XLEN-1:0]  rs1_data_ex_o,
    output logic [XLEN-1:0]  rs2_data_ex_o,
    output logic [XLEN-1:0]  imm_ex_o,
    output logic [4:0]       rs1_label_ex_o,
    output logic [4:0]       rs2_label_ex_o,
    output logic [4:0]       rd_label_ex_o,
    output logic [3:0]       alu_op_ex_o,
    output logic             alu_src_ex_o,
    output logic             is_load_instruction_ex_o,
    output logic             is_store_ex_o,
    output logic             reg_write_ex_o,
    output logic             mem_to_reg_ex_o,
    output logic             branch_ex_o,
    output logic             load_store_forward_sel_ex_o,
    output logic [CNT_W-1:0] bubble_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // A kill and a bubble load the same dead-slot contents.
    logic kill_slot;
    // Control bits of a captured instruction only survive when ID holds a real instruction.
    logic ctrl_keep;

    // Classify the slot that enters EX on this edge.
    always_comb begin
        kill_slot = flush_i | stall_i;
        ctrl_keep = valid_id_i;
    end

    // Pipeline register with the priority reset > hold > flush/stall > capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_ex_o                  <= 1'b0;
            pc_ex_o                     <= '0;
            rs1_data_ex_o               <= '0;
            rs2_data_ex_o               <= '0;
            imm_ex_o                    <= '0;
            rs1_label_ex_o              <= '0;
            rs2_label_ex_o              <= '0;
            rd_label_ex_o               <= '0;
            alu_op_ex_o                 <= '0;
            alu_src_ex_o                <= 1'b0;
            is_load_instruction_ex_o    <= 1'b0;
            is_store_ex_o               <= 1'b0;
            reg_write_ex_o              <= 1'b0;
            mem_to_reg_ex_o             <= 1'b0;
            branch_ex_o                 <= 1'b0;
            load_store_forward_sel_ex_o <= 1'b0;
        end else if (!hold_i) begin
            if (kill_slot) begin
                valid_ex_o                  <= 1'b0;
                rs1_label_ex_o              <= '0;
                rs2_label_ex_o              <= '0;
                rd_label_ex_o               <= '0;
                alu_op_ex_o                 <= '0;
                alu_src_ex_o                <= 1'b0;
                is_load_instruction_ex_o    <= 1'b0;
                is_store_ex_o               <= 1'b0;
                reg_write_ex_o              <= 1'b0;
                mem_to_reg_ex_o             <= 1'b0;
                branch_ex_o                 <= 1'b0;
                load_store_forward_sel_ex_o <= 1'b0;
            end else begin
                valid_ex_o                  <= valid_id_i;
                pc_ex_o                     <= pc_id_i;
                rs1_data_ex_o               <= rs1_data_id_i;
                rs2_data_ex_o               <= rs2_data_id_i;
                imm_ex_o                    <= imm_id_i;
                rs1_label_ex_o              <= rs1_label_id_i;
                rs2_label_ex_o              <= rs2_label_id_i;
                rd_label_ex_o               <= rd_label_id_i;
                alu_op_ex_o                 <= ctrl_keep ? alu_op_id_i : 4'd0;
                alu_src_ex_o                <= ctrl_keep & alu_src_id_i;
                is_load_instruction_ex_o    <= ctrl_keep & is_load_id_i;
                is_store_ex_o               <= ctrl_keep & is_store_id_i;
                reg_write_ex_o              <= ctrl_keep & reg_write_id_i;
                mem_to_reg_ex_o             <= ctrl_keep & mem_to_reg_id_i;
                branch_ex_o                 <= ctrl_keep & branch_id_i;
                load_store_forward_sel_ex_o <= ctrl_keep & load_store_forward_sel_i;
            end
        end
    end

    // Saturating event counters; flush takes precedence, so a simultaneous stall is not counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_count_o <= '0;
            flush_count_o  <= '0;
        end else if (!hold_i) begin
            if (flush_i) begin
                if (flush_count_o != CNT_MAX) begin
                    flush_count_o <= flush_count_o + CNT_W'(1);
                end
            end else if (stall_i) begin
                if (bubble_count_o != CNT_MAX) begin
                    bubble_count_o <= bubble_count_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Self-checking bench for id_ex_pipeline_register.
// Directed scenarios are followed by randomized traffic. Everything is checked
// against a behavioural model of the stage's rules.
module tb_id_ex_pipeline_register;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic rst, hold, flush, stall, fwd_sel, valid_id;
    logic [XLEN-1:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
    logic [4:0] rs1_label_id, rs2_label_id, rd_label_id;
    logic [3:0] alu_op_id;
    logic alu_src_id, is_load_id, is_store_id, reg_write_id, mem_to_reg_id, branch_id;

    logic valid_ex;
    logic [XLEN-1:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0] rs1_label_ex, rs2_label_ex, rd_label_ex;
    logic [3:0] alu_op_ex;
    logic alu_src_ex, is_load_ex, is_store_ex, reg_write_ex, mem_to_reg_ex, branch_ex, fwd_sel_ex;
    logic [CNT_W-1:0] bubble_count, flush_count;

    // Model of the expected EX-side state.
    logic m_valid, m_alu_src, m_load, m_store, m_rw, m_m2r, m_br, m_fwd;
    logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0] m_rs1l, m_rs2l, m_rdl;
    logic [3:0] m_alu_op;
    int m_bubbles, m_flushes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .stall_i(stall),
        .load_store_forward_sel_i(fwd_sel), .valid_id_i(valid_id),
        .pc_id_i(pc_id), .rs1_data_id_i(rs1_data_id), .rs2_data_id_i(rs2_data_id), .imm_id_i(imm_id),
        .rs1_label_id_i(rs1_label_id), .rs2_label_id_i(rs2_label_id), .rd_label_id_i(rd_label_id),
        .alu_op_id_i(alu_op_id), .alu_src_id_i(alu_src_id), .is_load_id_i(is_load_id),
        .is_store_id_i(is_store_id), .reg_write_id_i(reg_write_id), .mem_to_reg_id_i(mem_to_reg_id),
        .branch_id_i(branch_id),
        .valid_ex_o(valid_ex), .pc_ex_o(pc_ex), .rs1_data_ex_o(rs1_data_ex), .rs2_data_ex_o(rs2_data_ex),
        .imm_ex_o(imm_ex), .rs1_label_ex_o(rs1_label_ex), .rs2_label_ex_o(rs2_label_ex),
        .rd_label_ex_o(rd_label_ex), .alu_op_ex_o(alu_op_ex), .alu_src_ex_o(alu_src_ex),
        .is_load_instruction_ex_o(is_load_ex), .is_store_ex_o(is_store_ex),
        .reg_write_ex_o(reg_write_ex), .mem_to_reg_ex_o(mem_to_reg_ex), .branch_ex_o(branch_ex),
        .load_store_forward_sel_ex_o(fwd_sel_ex),
        .bubble_count_o(bubble_count), .flush_count_o(flush_count)
    );

    // One comparison: count it and report a failure with observed and expected values.
    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the inputs presented for that edge.
    task automatic model_edge();
        logic dead;
        if (rst) begin
            {m_valid, m_alu_src, m_load, m_store, m_rw, m_m2r, m_br, m_fwd} = '0;
            {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
            {m_rs1l, m_rs2l, m_rdl, m_alu_op} = '0;
            m_bubbles = 0;
            m_flushes = 0;
        end else if (!hold) begin
            dead = flush || stall;
            if (flush) m_flushes = (m_flushes < int'(CNT_MAX)) ? m_flushes + 1 : m_flushes;
            else if (stall) m_bubbles = (m_bubbles < int'(CNT_MAX)) ? m_bubbles + 1 : m_bubbles;
            if (!dead) begin
                m_pc = pc_id; m_rs1d = rs1_data_id; m_rs2d = rs2_data_id; m_imm = imm_id;
            end
            m_valid  = !dead && valid_id;
            m_rs1l   = dead ? 5'd0 : rs1_label_id;
            m_rs2l   = dead ? 5'd0 : rs2_label_id;
            m_rdl    = dead ? 5'd0 : rd_label_id;
            m_alu_op = m_valid ? alu_op_id : 4'd0;
            m_alu_src = m_valid && alu_src_id;
            m_load   = m_valid && is_load_id;
            m_store  = m_valid && is_store_id;
            m_rw     = m_valid && reg_write_id;
            m_m2r    = m_valid && mem_to_reg_id;
            m_br     = m_valid && branch_id;
            m_fwd    = m_valid && fwd_sel;
        end
    endtask

    // Compare every output against the model.
    task automatic checkOutput(input string tag);
        chk({tag, ".valid"}, XLEN'(valid_ex), XLEN'(m_valid));
        chk({tag, ".pc"}, pc_ex, m_pc);
        chk({tag, ".rs1_data"}, rs1_data_ex, m_rs1d);
        chk({tag, ".rs2_data"}, rs2_data_ex, m_rs2d);
        chk({tag, ".imm"}, imm_ex, m_imm);
        chk({tag, ".labels"}, XLEN'({rs1_label_ex, rs2_label_ex, rd_label_ex}), XLEN'({m_rs1l, m_rs2l, m_rdl}));
        chk({tag, ".alu_op"}, XLEN'(alu_op_ex), XLEN'(m_alu_op));
        chk({tag, ".ctrl"}, XLEN'({alu_src_ex, is_load_ex, is_store_ex, reg_write_ex, mem_to_reg_ex, branch_ex}),
            XLEN'({m_alu_src, m_load, m_store, m_rw, m_m2r, m_br}));
        chk({tag, ".fwd_sel"}, XLEN'(fwd_sel_ex), XLEN'(m_fwd));
        chk({tag, ".bubble_count"}, XLEN'(bubble_count), XLEN'(m_bubbles));
        chk({tag, ".flush_count"}, XLEN'(flush_count), XLEN'(m_flushes));
    endtask

    // Apply one edge: update the model at the edge, then sample on the falling edge.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Present an instruction on the ID side.
    task automatic set_id(input logic v, input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] op,
                          input logic src, input logic ld, input logic st, input logic rw,
                          input logic m2r, input logic br);
        valid_id = v; pc_id = pc; rs1_label_id = rs1; rs2_label_id = rs2; rd_label_id = rd;
        alu_op_id = op; alu_src_id = src; is_load_id = ld; is_store_id = st;
        reg_write_id = rw; mem_to_reg_id = m2r; branch_id = br;
        rs1_data_id = pc ^ 32'hA5A5_0000; rs2_data_id = pc ^ 32'h0000_5A5A; imm_id = pc + 32'd4;
    endtask

    initial begin
        hold = 0; flush = 0; stall = 0; fwd_sel = 0;
        m_bubbles = 0; m_flushes = 0;

        // Reset with every ID input driven nonzero.
        rst = 1; hold = 1; flush = 1; stall = 1; fwd_sel = 1;
        set_id(1, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd3, 4'hF, 1, 1, 1, 1, 1, 1);
        applyStimulus("reset0");
        applyStimulus("reset1");

        // First capture after reset.
        rst = 0; hold = 0; flush = 0; stall = 0; fwd_sel = 0;
        set_id(1, 32'h100, 5'd0, 5'd0, 5'd5, 4'd0, 0, 0, 0, 1, 0, 0);
        applyStimulus("first");
        chk("first.pc_direct", pc_ex, 32'h100);
        chk("first.rd_direct", XLEN'(rd_label_ex), 32'd5);

        // Load-use: lw x5, then add x6,x5,x1 stalled for one edge.
        set_id(1, 32'h104, 5'd2, 5'd0, 5'd5, 4'd0, 1, 1, 0, 1, 1, 0);
        applyStimulus("lw");
        set_id(1, 32'h108, 5'd5, 5'd1, 5'd6, 4'd0, 0, 0, 0, 1, 0, 0);
        stall = 1;
        applyStimulus("bubble");
        chk("bubble.valid_direct", XLEN'(valid_ex), 32'd0);
        chk("bubble.is_load_direct", XLEN'(is_load_ex), 32'd0);
        stall = 0;
        applyStimulus("add");
        chk("add.rd_direct", XLEN'(rd_label_ex), 32'd6);
        chk("add.bubbles_direct", XLEN'(bubble_count), 32'd1);

        // Load-store forward: sw x5 with forward select, no bubble.
        set_id(1, 32'h10C, 5'd2, 5'd5, 5'd0, 4'd0, 1, 0, 1, 0, 0, 0);
        fwd_sel = 1;
        applyStimulus("sw_fwd");
        chk("sw_fwd.fwd_direct", XLEN'(fwd_sel_ex), 32'd1);
        fwd_sel = 0;

        // Flush and stall together: flush wins, data held.
        set_id(1, 32'h300, 5'd7, 5'd8, 5'd9, 4'd3, 1, 0, 0, 1, 0, 1);
        flush = 1; stall = 1;
        applyStimulus("flush_stall");
        chk("flush_stall.pc_held", pc_ex, 32'h10C);
        chk("flush_stall.flushes_direct", XLEN'(flush_count), 32'd1);
        flush = 0; stall = 0;

        // Hold for three edges while other controls and ID toggle.
        set_id(1, 32'h200, 5'd3, 5'd4, 5'd10, 4'd2, 0, 0, 0, 1, 0, 0);
        applyStimulus("pre_hold");
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            flush = i[0]; stall = ~i[0];
            set_id(1, 32'h400 + 32'(i), 5'd11, 5'd12, 5'd13, 4'd5, 1, 1, 1, 1, 1, 1);
            applyStimulus("hold");
        end
        chk("hold.pc_direct", pc_ex, 32'h200);
        hold = 0; flush = 0; stall = 1;
        applyStimulus("post_hold");
        stall = 0;

        // Invalid instruction: controls forced off, labels still captured.
        set_id(0, 32'h500, 5'd14, 5'd15, 5'd16, 4'd7, 1, 1, 1, 1, 1, 1);
        fwd_sel = 1;
        applyStimulus("invalid");
        fwd_sel = 0;

        // Bubble counter saturation.
        stall = 1;
        for (int i = 0; i < 20; i++) applyStimulus("sat");
        chk("sat.bubbles_direct", XLEN'(bubble_count), 32'd15);
        stall = 0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 31) == 0);
            hold  = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 4) == 0);
            fwd_sel = 1'($urandom);
            valid_id = ($urandom_range(0, 3) != 0);
            pc_id = $urandom; rs1_data_id = $urandom; rs2_data_id = $urandom; imm_id = $urandom;
            rs1_label_id = 5'($urandom); rs2_label_id = 5'($urandom); rd_label_id = 5'($urandom);
            alu_op_id = 4'($urandom);
            {alu_src_id, is_load_id, is_store_id, reg_write_id, mem_to_reg_id, branch_id} = 6'($urandom);
            applyStimulus("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
